// File: rtl/dred_eval.sv
// Reduced-dimension function evaluator: y = L[A*x] over GF(2), two-stage pipeline
// with CFG/RUN/DRAIN configuration control. Define DRED_STATS_EN to add out_cnt.
module dred_eval #(
  parameter int N = 8,
  parameter int K = 6,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic         cfg_sel,
  input  logic [7:0]   cfg_addr,
  input  logic [N-1:0] cfg_data,
  input  logic         cfg_commit,
  input  logic         cfg_reopen,
  output logic [1:0]   cfg_mode,
  output logic         cfg_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_y
`ifdef DRED_STATS_EN
  ,
  output logic [15:0]  out_cnt
`endif
);

  localparam int LUT_D = 1 << K;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   row_q [K];
  logic [M-1:0]   lut_q [LUT_D];

  logic           en;
  logic           addr_ok;
  logic           cfg_wr;
  logic [K-1:0]   red_d;

  logic           vld_p1;
  logic [K-1:0]   red_p1;
  logic           vld_p2;
  logic [M-1:0]   y_p2;

  function automatic logic gf2_dot(input logic [N-1:0] a, input logic [N-1:0] b);
    return ^(a & b);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign en        = !vld_p2 || out_ready;
  assign in_ready  = (state == ST_RUN) && en;
  assign out_valid = vld_p2;
  assign out_y     = y_p2;
  assign cfg_mode  = state;

  // Address range depends on the target: K rows or 2^K LUT words.
  assign addr_ok = cfg_sel ? (32'(cfg_addr) < LUT_D) : (32'(cfg_addr) < K);
  assign cfg_wr  = cfg_we && (state == ST_CFG) && addr_ok;

  always_comb begin
    red_d = '0;
    for (int i = 0; i < K; i++) begin
      red_d[i] = gf2_dot(in_x, row_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CFG;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      case (state)
        ST_CFG:   if (cfg_commit) state <= ST_RUN;
        ST_RUN:   if (cfg_reopen) state <= ST_DRAIN;
        ST_DRAIN: if (!vld_p1 && !vld_p2) state <= ST_CFG;
        default:  state <= ST_CFG;
      endcase
      if (cfg_we && ((state != ST_CFG) || !addr_ok)) begin
        cfg_err <= 1'b1;
      end
      if (en) begin
        vld_p1 <= in_valid && in_ready;
        vld_p2 <= vld_p1;
      end
    end
  end

  // Configuration storage: identity projection and zero LUT out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        row_q[i] <= N'(1) << i;
      end
      for (int j = 0; j < LUT_D; j++) begin
        lut_q[j] <= '0;
      end
    end else if (cfg_wr) begin
      if (cfg_sel) begin
        lut_q[cfg_addr[K-1:0]] <= cfg_data[M-1:0];
      end else begin
        for (int i = 0; i < K; i++) begin
          if (32'(cfg_addr) == i) row_q[i] <= cfg_data;
        end
      end
    end
  end

  // Stage 1: reduced vector A*x
  always_ff @(posedge clk) begin
    if (en) begin
      red_p1 <= red_d;
    end
  end

  // Stage 2: LUT read; out_y has a defined reset value
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p2 <= '0;
    end else if (en) begin
      y_p2 <= lut_q[red_p1];
    end
  end

`ifdef DRED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || ((state == ST_CFG) && cfg_commit)) begin
      out_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      out_cnt <= sat_inc(out_cnt);
    end
  end
`else
  logic [15:0] unused_cnt;
  assign unused_cnt = sat_inc(16'd0);
`endif

endmodule

// File: doc/dred_eval.md
DRED_EVAL -- requirements
Module: dred_eval

Interface
REQ-001 Parameter N, default 8: primary input width.
REQ-002 Parameter K, default 6: reduced-variable count, 1 <= K <= N, K <= 8.
REQ-003 Parameter M, default 1: output width, M <= N.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  configuration write strobe.
REQ-007 cfg_sel  in  1  write target: 0 = reduction-matrix row, 1 = LUT word.
REQ-008 cfg_addr  in  8  row index (0..K-1) or LUT index (0..2^K-1).
REQ-009 cfg_data  in  N  row mask (N bits) or LUT word (low M bits used).
REQ-010 cfg_commit  in  1  leave CFG and enter RUN.
REQ-011 cfg_reopen  in  1  request return to CFG.
REQ-012 cfg_mode  out  2  current state: 0 = CFG, 1 = RUN, 2 = DRAIN.
REQ-013 cfg_err  out  1  sticky illegal-configuration flag.
REQ-014 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-015 in_x  in  N  input vector.
REQ-016 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 out_y  out  M  function value.

Function
REQ-018 The block SHALL evaluate f(x) = L[A*x], with A a K-by-N GF(2) matrix and L a 2^K-entry M-bit LUT: reduced bit i = XOR over (in_x AND row_i).
REQ-019 States: CFG -> RUN on cfg_commit; RUN -> DRAIN on cfg_reopen; DRAIN -> CFG once both pipeline stages are empty. cfg_commit outside CFG is ignored.
REQ-020 A cfg_we in CFG SHALL write the row or LUT word in the same cycle.
REQ-021 A cfg_we outside CFG, or with an out-of-range cfg_addr, SHALL be ignored and SHALL set cfg_err.
REQ-022 in_ready SHALL be 1 only in RUN and only when en = (!out_valid || out_ready).
REQ-023 Pipeline: stage 1 registers A*x; stage 2 registers the LUT read. Latency SHALL be exactly 2 cycles from input handshake to out_valid when there is no stall.
REQ-024 When en = 0, both stages and their valid bits SHALL hold; out_y SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Back-to-back input handshakes SHALL give one output per cycle (full throughput).
REQ-026 In DRAIN, in-flight data SHALL complete normally, with no loss or duplication.
REQ-027 cfg_commit and cfg_reopen asserted together SHALL be treated as cfg_commit in CFG and as cfg_reopen in RUN.

Reset
REQ-028 On rst: state = CFG; both stage valid bits = 0; out_valid = 0; out_y = 0; in_ready = 0; cfg_err = 0.
REQ-029 On rst: row_i = one-hot bit i (identity projection onto in_x[K-1:0]); every LUT entry = 0.
REQ-030 rst mid-stream SHALL discard in-flight data; no out_valid until after a new commit and a new input.

Configuration
REQ-031 Macro DRED_STATS_EN.
- Defined: output port out_cnt (16 bits) counts output handshakes, saturates at 0xFFFF, and is cleared by rst and by the CFG->RUN transition.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Verification
REQ-032 Default params; reset; commit with no writes; in_x = 0x2A -> out_y = 0 two cycles later, cfg_mode = 1.
REQ-033 Load LUT[0x2A] = 1; commit; in_x = 0xEA -> out_y = 1 (top bits masked by identity rows); in_x = 0x2B -> out_y = 0.
REQ-034 Set row0 = 0xFF, others identity; LUT[i] = i[0]; stream 0x00, 0x01, 0x03, 0xFF back-to-back -> out_y = 0, 1, 0, 0 on consecutive cycles.
REQ-035 Hold out_ready = 0 for 5 cycles during a 3-word stream -> in_ready drops, out_y is stable, all 3 results arrive in order.
REQ-036 cfg_reopen with 2 words in flight -> both words are delivered, then cfg_mode = 0; a cfg_we in RUN sets cfg_err = 1.
REQ-037 With DRED_STATS_EN: 4 handshakes -> out_cnt = 4; recommit -> out_cnt = 0.
